// File: rtl/add_arbiter_pkg.sv
// Shared types and constants for the two-requester arbitrated adder.
// State encoding is fixed so that waveforms and external monitors can decode it.
package add_arbiter_pkg;

    localparam int OPND_W = 3;
    localparam int RES_W  = OPND_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        RESP    = 2'd2
    } state_t;

    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
    } operands_t;

endpackage

// File: rtl/add_arbiter_adder3.sv
// 3-bit ripple-carry adder built from per-bit full adders, carry-in tied low.
module adder3
    import add_arbiter_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [OPND_W-1:0] sum,
    output logic              carry
);

    logic [OPND_W:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < OPND_W; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign carry = c[OPND_W];

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter for two requesters sharing one 3-bit adder.
// One operation in flight: IDLE (grant + latch) -> COMPUTE (add) -> RESP (ack).
module add_arbiter
    import add_arbiter_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [OPND_W-1:0] a0,
    input  logic [OPND_W-1:0] b0,
    input  logic              req1,
    input  logic [OPND_W-1:0] a1,
    input  logic [OPND_W-1:0] b1,
    output logic              ack0,
    output logic              ack1,
    output logic [RES_W-1:0]  result,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    state_t             state_q, state_d;
    logic               grant_valid;
    logic               grant_id;
    logic               latch_en;
    logic               winner_q;
    logic               last_q;
    operands_t          opnd_q;
    logic [RES_W-1:0]   result_q;
    logic [OPND_W-1:0]  sum;
    logic               carry;
    logic [CNT_W-1:0]   op_count_q;

    // ---------------- controller ----------------

    // A lone requester always wins; on a tie the one not served last wins.
    assign grant_valid = req0 | req1;
    assign grant_id    = (req0 && req1) ? ~last_q : req1;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d  = state_q;
        latch_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d  = COMPUTE;
                    latch_en = 1'b1;
                end
            end
            COMPUTE: state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        ack0   = 1'b0;
        ack1   = 1'b0;
        result = '0;
        if (state_q == RESP) begin
            ack0   = ~winner_q;
            ack1   = winner_q;
            result = result_q;
        end
    end

    assign busy     = (state_q != IDLE);
    assign op_count = op_count_q;

    // ---------------- datapath ----------------

    adder3 u_adder3 (
        .a     (opnd_q.a),
        .b     (opnd_q.b),
        .sum   (sum),
        .carry (carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            winner_q <= 1'b0;
            opnd_q   <= '0;
        end else if (latch_en) begin
            winner_q <= grant_id;
            opnd_q   <= grant_id ? operands_t'{a: a1, b: b1} : operands_t'{a: a0, b: b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
        end else if (state_q == COMPUTE) begin
            result_q <= {carry, sum};
        end
    end

    // Requester 0 must win the first tie after reset, hence last starts at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q     <= 1'b1;
            op_count_q <= '0;
        end else if (state_q == RESP) begin
            last_q     <= winner_q;
            op_count_q <= op_count_q + CNT_W'(1);
        end
    end

endmodule
